// File: rtl/alu_intf_pkg.sv
// Command bytes shared between the host-side master and the on-board command responder,
// plus the master FSM state encoding.
package alu_intf_pkg;

  localparam int unsigned ALU_CMD_W = 8;

  localparam logic [ALU_CMD_W-1:0] ALU_OP_GET_RES = 8'h00;
  localparam logic [ALU_CMD_W-1:0] ALU_OP_SET_A   = 8'h01;
  localparam logic [ALU_CMD_W-1:0] ALU_OP_SET_B   = 8'h02;
  localparam logic [ALU_CMD_W-1:0] ALU_OP_SET_OP  = 8'h03;

  // A full transaction is seven bytes: three (command, value) pairs then GET_RES.
  localparam logic [2:0] LAST_BYTE_IDX = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_RSP,
    ST_DONE
  } master_state_e;

endpackage

// File: rtl/alu_cmd_master_rsp_timeout_counter.sv
// Response watchdog: cycle counter with synchronous clear and count enable.
// o_tc is high on the enabled cycle in which the count sits at LIMIT-1.
module rsp_timeout_counter #(
  parameter int LIMIT = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int NB_CNT = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [NB_CNT-1:0] TERM = NB_CNT'(LIMIT - 1);

  logic [NB_CNT-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_tc = i_en && (cnt_q == TERM);

endmodule

// File: rtl/alu_cmd_master.sv
// Host-side UART-to-ALU initiator: one start sends SET_A/A, SET_B/B, SET_OP/op, GET_RES, then waits for the result byte.
// Optional response watchdog compiled in with ALU_CMD_TIMEOUT_EN; all outputs are registered.
module alu_cmd_master #(
  parameter int NB_DATA     = 8,
  parameter int NB_ALU_OP   = 6,
  parameter int RSP_TIMEOUT = 1_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [NB_DATA-1:0]   i_A,
  input  logic [NB_DATA-1:0]   i_B,
  input  logic [NB_ALU_OP-1:0] i_op,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NB_DATA-1:0]   o_result,
  output logic                 o_timeout,
  output logic                 o_tx_start,
  output logic [NB_DATA-1:0]   o_tx_data,
  input  logic                 i_tx_done,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_rx_done
);

  import alu_intf_pkg::*;

  if (NB_ALU_OP > NB_DATA || RSP_TIMEOUT < 2) begin : g_param_chk
    $error("alu_cmd_master: NB_ALU_OP must fit in NB_DATA and RSP_TIMEOUT must be >= 2");
  end

  master_state_e state_q, state_d;

  logic [2:0]           idx_q, idx_d;
  logic [NB_DATA-1:0]   a_q, b_q, rx_q, byte_sel;
  logic [NB_ALU_OP-1:0] op_q;

  logic latch_ops, tx_start_d, busy_d, done_d, timeout_d, cap_rx, load_result;
  logic rsp_tc;

`ifdef ALU_CMD_TIMEOUT_EN
  logic cnt_clr, cnt_en;

  // Held clear outside WAIT_RSP so the count starts at zero on entry.
  assign cnt_en  = (state_q == ST_WAIT_RSP);
  assign cnt_clr = !cnt_en;

  rsp_timeout_counter #(
    .LIMIT (RSP_TIMEOUT)
  ) u_rsp_timeout (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (cnt_clr),
    .i_en    (cnt_en),
    .o_tc    (rsp_tc)
  );
`else
  assign rsp_tc = 1'b0;
`endif

  always_comb begin
    byte_sel = '0;
    case (idx_q)
      3'd0:    byte_sel = NB_DATA'(ALU_OP_SET_A);
      3'd1:    byte_sel = a_q;
      3'd2:    byte_sel = NB_DATA'(ALU_OP_SET_B);
      3'd3:    byte_sel = b_q;
      3'd4:    byte_sel = NB_DATA'(ALU_OP_SET_OP);
      3'd5:    byte_sel = NB_DATA'(op_q);
      default: byte_sel = NB_DATA'(ALU_OP_GET_RES);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    latch_ops   = 1'b0;
    tx_start_d  = 1'b0;
    busy_d      = o_busy;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    cap_rx      = 1'b0;
    load_result = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          latch_ops = 1'b1;
          idx_d     = 3'd0;
          busy_d    = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_start_d = 1'b1;
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          if (idx_q == LAST_BYTE_IDX) begin
            state_d = ST_WAIT_RSP;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SEND;
          end
        end
      end
      ST_WAIT_RSP: begin
        // A response arriving on the terminal cycle beats the watchdog.
        if (i_rx_done) begin
          cap_rx  = 1'b1;
          state_d = ST_DONE;
        end else if (rsp_tc) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_DONE: begin
        done_d      = 1'b1;
        load_result = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rx_q       <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_timeout  <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_result   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
      o_timeout  <= timeout_d;
      o_tx_start <= tx_start_d;
      if (latch_ops) begin
        a_q  <= i_A;
        b_q  <= i_B;
        op_q <= i_op;
      end
      if (tx_start_d) begin
        o_tx_data <= byte_sel;
      end
      if (cap_rx) begin
        rx_q <= i_rx_data;
      end
      if (load_result) begin
        o_result <= rx_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_master.sv
// Directed bench for alu_cmd_master with a UART TX model answering 10 cycles after each start.
module tb_alu_cmd_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_A = 8'h00;
  logic [7:0] i_B = 8'h00;
  logic [5:0] i_op = 6'h00;
  logic       i_tx_done = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_done = 1'b0;
  logic       o_busy, o_done, o_timeout, o_tx_start;
  logic [7:0] o_result, o_tx_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int tx_timer = 0;
  logic [7:0] tx_q[$];
  int         st_q[$];

  alu_cmd_master #(
    .NB_DATA     (8),
    .NB_ALU_OP   (6),
    .RSP_TIMEOUT (16)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_start    (i_start),
    .i_A        (i_A),
    .i_B        (i_B),
    .i_op       (i_op),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_timeout  (o_timeout),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_done  (i_tx_done),
    .i_rx_data  (i_rx_data),
    .i_rx_done  (i_rx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // UART TX model: records every byte with its cycle stamp, reports done 10 cycles later.
  always @(negedge clk) begin
    i_tx_done = 1'b0;
    if (!rst_n) begin
      tx_timer = 0;
    end else if (o_tx_start) begin
      tx_q.push_back(o_tx_data);
      st_q.push_back(cyc);
      tx_timer = 10;
    end else if (tx_timer > 0) begin
      tx_timer--;
      if (tx_timer == 0) i_tx_done = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 400 && tx_q.size() < n; i++) @(negedge clk);
    chk("tx_count_reached", 32'(tx_q.size() >= n), 32'd1);
  endtask

  task automatic start_txn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    i_A = a; i_B = b; i_op = op; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic respond(input logic [7:0] d);
    i_rx_data = d; i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic chk_bytes(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic [7:0] exp [7];
    exp = '{8'h01, a, 8'h02, b, 8'h03, {2'b00, op}, 8'h00};
    for (int i = 0; i < 7; i++) chk($sformatf("byte%0d", i), tx_q[i], exp[i]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     o_busy,     0);
    chk({tag, "_done"},     o_done,     0);
    chk({tag, "_timeout"},  o_timeout,  0);
    chk({tag, "_tx_start"}, o_tx_start, 0);
    chk({tag, "_tx_data"},  o_tx_data,  0);
    chk({tag, "_result"},   o_result,   0);
  endtask

  logic all_busy, any_to;
  int   t_to;

  initial begin
    // Reset state
    cyc_n(2);
    chk_all_zero("reset");
    rst_n = 1'b1;
    cyc_n(2);

    // Basic transaction and first-byte latency
    start_txn(8'h05, 8'h03, 6'h20);
    chk("accept_busy", o_busy, 1);
    chk("accept_no_tx", o_tx_start, 0);
    @(negedge clk);
    chk("first_tx_start", o_tx_start, 1);
    chk("first_tx_data", o_tx_data, 8'h01);
    wait_tx(7);
    cyc_n(15);
    chk("t1_tx_count", tx_q.size(), 7);
    chk_bytes(8'h05, 8'h03, 6'h20);
    chk("byte_spacing", st_q[1] - st_q[0], 12);
    respond(8'h08);
    chk("t1_done_early", o_done, 0);
    chk("t1_busy_wait", o_busy, 1);
    @(negedge clk);
    chk("t1_done", o_done, 1);
    chk("t1_result", o_result, 8'h08);
    chk("t1_busy_fall", o_busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", o_done, 0);
    chk("t1_result_hold", o_result, 8'h08);
    cyc_n(2);

    // Held start plus mid-transaction start with new operands
    tx_q.delete(); st_q.delete();
    i_A = 8'h11; i_B = 8'h22; i_op = 6'h3F; i_start = 1'b1;
    cyc_n(3);
    i_start = 1'b0;
    cyc_n(30);
    i_A = 8'hAA; i_B = 8'hBB; i_op = 6'h15; i_start = 1'b1;
    cyc_n(1);
    i_start = 1'b0;
    wait_tx(7);
    cyc_n(15);
    chk("t2_tx_count", tx_q.size(), 7);
    chk_bytes(8'h11, 8'h22, 6'h3F);
    respond(8'h99);
    @(negedge clk);
    chk("t2_done", o_done, 1);
    chk("t2_result", o_result, 8'h99);
    cyc_n(20);
    chk("t2_idle", o_busy, 0);
    chk("t2_no_extra_txn", tx_q.size(), 7);

    // Stray RX during command transmission is ignored
    tx_q.delete(); st_q.delete();
    start_txn(8'h7E, 8'h81, 6'h01);
    wait_tx(4);
    cyc_n(2);
    respond(8'hFF);
    cyc_n(3);
    chk("t3_still_busy", o_busy, 1);
    chk("t3_no_done", o_done, 0);
    wait_tx(7);
    cyc_n(15);
    chk("t3_busy_wait", o_busy, 1);
    chk("t3_result_prior", o_result, 8'h99);
    chk("t3_byte3", tx_q[3], 8'h81);
    respond(8'h42);
    @(negedge clk);
    chk("t3_done", o_done, 1);
    chk("t3_result", o_result, 8'h42);
    cyc_n(3);

    // Asynchronous reset mid-transaction, then a fresh start
    tx_q.delete(); st_q.delete();
    start_txn(8'h10, 8'h20, 6'h05);
    wait_tx(4);
    cyc_n(1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    cyc_n(2);
    rst_n = 1'b1;
    cyc_n(15);
    tx_q.delete(); st_q.delete();
    start_txn(8'h10, 8'h20, 6'h05);
    wait_tx(7);
    cyc_n(15);
    chk("t4_restart_byte0", tx_q[0], 8'h01);
    chk("t4_restart_byte1", tx_q[1], 8'h10);
    chk("t4_tx_count", tx_q.size(), 7);
    respond(8'h55);
    @(negedge clk);
    chk("t4_result", o_result, 8'h55);
    cyc_n(3);

    // No response: watchdog if compiled in, otherwise wait indefinitely
    tx_q.delete(); st_q.delete();
    start_txn(8'h01, 8'h02, 6'h03);
    wait_tx(7);
`ifdef ALU_CMD_TIMEOUT_EN
    for (int i = 0; i < 100 && !o_timeout; i++) @(negedge clk);
    t_to = cyc;
    chk("to_seen", o_timeout, 1);
    chk("to_delay", t_to - st_q[6], 27);
    chk("to_result_kept", o_result, 8'h55);
    chk("to_busy_fall", o_busy, 0);
    chk("to_no_done", o_done, 0);
    @(negedge clk);
    chk("to_pulse", o_timeout, 0);
`else
    all_busy = 1'b1;
    any_to   = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (!o_busy) all_busy = 1'b0;
      if (o_timeout) any_to = 1'b1;
    end
    chk("nto_busy_held", all_busy, 1);
    chk("nto_no_timeout", any_to, 0);
    chk("nto_result_kept", o_result, 8'h55);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
